// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX-stage forwarding select generation for the 5-stage core.
// Tracks destination info of the instructions in EX and MEM.
package riscv_pkg;
   typedef enum logic [1:0] {
      from_Reg    = 2'b00,
      from_mem_wb = 2'b01,
      from_ex_mem = 2'b10
   } fwd_e;
endpackage

module hazard_fwd_unit
   import riscv_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   input  logic                  flush,
   output logic                  stall,
   output fwd_e                  ForwardA,
   output fwd_e                  ForwardB,
   output logic [CNT_W-1:0]      stall_cnt
);

   // WB occupancy is not tracked: a distance-3 producer is covered by the
   // write-first register file, so nothing past MEM is ever consulted.
   logic                  ex_vld;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_reg_write;
   logic                  ex_is_load;
   logic                  mem_vld;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  mem_reg_write;

   logic                  bubble;
   fwd_e                  fwd_a_nxt;
   fwd_e                  fwd_b_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic ex_writes(input logic [REG_ADDR_W-1:0] x);
      return ex_vld && ex_reg_write && (ex_rd == x) && (ex_rd != '0);
   endfunction

   function automatic logic mem_writes(input logic [REG_ADDR_W-1:0] x);
      return mem_vld && mem_reg_write && (mem_rd == x) && (mem_rd != '0);
   endfunction

   function automatic fwd_e fwd_sel(input logic uses, input logic [REG_ADDR_W-1:0] rs);
      if (!uses)
         return from_Reg;
      else if (ex_writes(rs) && !ex_is_load)
         return from_ex_mem;
      else if (mem_writes(rs))
         return from_mem_wb;
      else
         return from_Reg;
   endfunction

   always_comb begin
      stall = id_valid && !flush && ex_vld && ex_is_load &&
              ((id_uses_rs1 && ex_writes(id_rs1)) || (id_uses_rs2 && ex_writes(id_rs2)));
      bubble    = stall || flush;
      fwd_a_nxt = fwd_sel(id_uses_rs1, id_rs1);
      fwd_b_nxt = fwd_sel(id_uses_rs2, id_rs2);
   end

   // ID -> EX -> MEM control advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_vld    <= 1'b0;
         mem_vld   <= 1'b0;
         ForwardA  <= from_Reg;
         ForwardB  <= from_Reg;
         stall_cnt <= '0;
      end else begin
         mem_vld  <= flush ? 1'b0 : ex_vld;
         ex_vld   <= bubble ? 1'b0 : id_valid;
         ForwardA <= bubble ? from_Reg : fwd_a_nxt;
         ForwardB <= bubble ? from_Reg : fwd_b_nxt;
         if (stall)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

   // ID -> EX -> MEM record payload; meaningless whenever the valid bit is low
   always_ff @(posedge clk) begin
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_reg_write;
      ex_is_load    <= id_is_load;
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding distances, load-use, x0,
// flush override, counter saturation (CNT_W=4) and asynchronous reset.
module tb_hazard_fwd_unit;
   import riscv_pkg::*;

   localparam int RW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid;
   logic [RW-1:0] id_rs1, id_rs2, id_rd;
   logic          id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
   logic          flush;
   logic          stall;
   fwd_e          ForwardA, ForwardB;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   hazard_fwd_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_rd       (id_rd),
      .id_reg_write(id_reg_write),
      .id_is_load  (id_is_load),
      .flush       (flush),
      .stall       (stall),
      .ForwardA    (ForwardA),
      .ForwardB    (ForwardB),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                         input logic u2, input int rd, input logic rw, input logic ld);
      id_valid     = v;
      id_rs1       = RW'(rs1);
      id_rs2       = RW'(rs2);
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      id_rd        = RW'(rd);
      id_reg_write = rw;
      id_is_load   = ld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pipe();
      set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) step();
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      #12;
      check("rst_stall", int'(stall), 0);
      check("rst_fwdA", int'(ForwardA), int'(from_Reg));
      check("rst_fwdB", int'(ForwardB), int'(from_Reg));
      check("rst_cnt", int'(stall_cnt), 0);
      rst_n = 1'b1;
      step();

      // back-to-back: add x5,x1,x2 then sub x6,x5,x7
      set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5, 7, 1'b1, 1'b1, 6, 1'b1, 1'b0);
      #1;
      check("b2b_stall", int'(stall), 0);
      step();
      set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("b2b_fwdA", int'(ForwardA), int'(from_ex_mem));
      check("b2b_fwdB", int'(ForwardB), int'(from_Reg));
      clear_pipe();

      // distance 2 through a nop, reader in rs2
      set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      step();
      set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      step();
      set_id(1'b1, 1, 5, 1'b1, 1'b1, 10, 1'b1, 1'b0);
      step();
      check("d2_fwdB", int'(ForwardB), int'(from_mem_wb));
      check("d2_fwdA", int'(ForwardA), int'(from_Reg));
      clear_pipe();

      // distance 2 with x5 rewritten in between: newer producer wins
      set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      step();
      set_id(1'b1, 3, 4, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      step();
      set_id(1'b1, 1, 5, 1'b1, 1'b1, 10, 1'b1, 1'b0);
      step();
      check("prio_fwdB", int'(ForwardB), int'(from_ex_mem));
      clear_pipe();

      // load-use: lw x8 then add x9,x8,x1
      set_id(1'b1, 2, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
      step();
      set_id(1'b1, 8, 1, 1'b1, 1'b1, 9, 1'b1, 1'b0);
      #1;
      check("lu_stall1", int'(stall), 1);
      step();
      check("lu_bubble_fwdA", int'(ForwardA), int'(from_Reg));
      check("lu_stall2", int'(stall), 0);
      check("lu_cnt", int'(stall_cnt), 1);
      step();
      check("lu_fwdA", int'(ForwardA), int'(from_mem_wb));
      check("lu_fwdB", int'(ForwardB), int'(from_Reg));
      check("lu_stall3", int'(stall), 0);
      clear_pipe();

      // x0 never forwards
      set_id(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0);
      step();
      set_id(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      step();
      check("x0_fwdA", int'(ForwardA), int'(from_Reg));
      check("x0_fwdB", int'(ForwardB), int'(from_Reg));
      clear_pipe();

      // load x3, consumer names x3 in rs2 but does not read it
      set_id(1'b1, 2, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
      step();
      set_id(1'b1, 4, 3, 1'b1, 1'b0, 11, 1'b1, 1'b0);
      #1;
      check("nouse_stall", int'(stall), 0);
      step();
      check("nouse_fwdB", int'(ForwardB), int'(from_Reg));
      check("nouse_cnt", int'(stall_cnt), 1);
      clear_pipe();

      // flush in the same cycle as a load-use
      set_id(1'b1, 2, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
      step();
      set_id(1'b1, 8, 1, 1'b1, 1'b1, 9, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      check("fl_stall", int'(stall), 0);
      step();
      flush = 1'b0;
      check("fl_fwdA", int'(ForwardA), int'(from_Reg));
      check("fl_fwdB", int'(ForwardB), int'(from_Reg));
      check("fl_cnt", int'(stall_cnt), 1);
      clear_pipe();

      // 20 further load-use stalls push the 4-bit counter past all-ones
      for (int i = 0; i < 20; i++) begin
         set_id(1'b1, 2, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
         step();
         set_id(1'b1, 8, 1, 1'b1, 1'b1, 9, 1'b1, 1'b0);
         step();
         step();
      end
      check("sat_cnt", int'(stall_cnt), 15);
      clear_pipe();

      // asynchronous reset in the middle of a stall
      set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
      step();
      set_id(1'b1, 8, 1, 1'b1, 1'b1, 9, 1'b1, 1'b0);
      #1;
      check("pre_rst_stall", int'(stall), 1);
      check("pre_rst_fwdA", int'(ForwardA), int'(from_ex_mem));
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", int'(stall), 0);
      check("mid_rst_fwdA", int'(ForwardA), int'(from_Reg));
      check("mid_rst_fwdB", int'(ForwardB), int'(from_Reg));
      check("mid_rst_cnt", int'(stall_cnt), 0);
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst_stall", int'(stall), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
